// File: rtl/mem_map_pkg.sv
// ============================================================================
// Module      : mem_map_pkg
// Description : Shared memory map, state and grant types for mem_access_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_map_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;
    localparam int OFF_W     = 4;
    localparam int INST_BASE = 0;
    localparam int DATA_BASE = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    // Zero-extended add; any carry out of ADDR_W is discarded.
    function automatic logic [ADDR_W-1:0] map_addr(input int base, input logic [OFF_W-1:0] off);
        return ADDR_W'(base) + {{(ADDR_W-OFF_W){1'b0}}, off};
    endfunction

endpackage

`default_nettype wire

// File: rtl/access_timer.sv
// ============================================================================
// Module      : access_timer
// Description : 4-bit loadable down-counter with zero flag for wait states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module access_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_zero = (r_count == 4'd0);

endmodule

`default_nettype wire

// File: rtl/mem_access_master.sv
// ============================================================================
// Module      : mem_access_master
// Description : Round-robin fetch/data requester for the shared 32x8 memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_master
    import mem_map_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [OFF_W-1:0]  if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_instr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [OFF_W-1:0]  d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t              r_state;
    state_t              w_next_state;
    grant_t              r_grant;
    grant_t              r_last_grant;
    grant_t              w_grant;
    logic                w_grant_any;
    logic                w_load;
    logic                w_dec;
    logic                w_zero;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_if_instr;
    logic [DATA_W-1:0]   r_d_rdata;

    access_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (4'(WAIT_CYCLES)),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_any  = 1'b0;
        w_grant      = GNT_FETCH;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            IDLE: begin
                if (if_req || d_req) begin
                    w_grant_any  = 1'b1;
                    // On a tie, the port that did not win last time goes first.
                    w_grant      = (if_req && (!d_req || (r_last_grant == GNT_DATA))) ? GNT_FETCH : GNT_DATA;
                    w_load       = 1'b1;
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (!w_zero) begin
                    w_dec = 1'b1;
                end else begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= GNT_FETCH;
            r_last_grant <= GNT_DATA;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_if_instr   <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (w_grant_any) begin
                r_grant      <= w_grant;
                r_last_grant <= w_grant;
                r_addr       <= (w_grant == GNT_FETCH) ? map_addr(INST_BASE, if_addr)
                                                       : map_addr(DATA_BASE, d_addr);
                r_we         <= (w_grant == GNT_DATA) && d_we;
                r_wdata      <= d_wdata;
            end
            if ((r_state == ACCESS) && w_zero && !r_we) begin
                if (r_grant == GNT_FETCH) begin
                    r_if_instr <= mem_rdata;
                end else begin
                    r_d_rdata  <= mem_rdata;
                end
            end
        end
    end

    // Memory-side outputs decode from state so reset silences them at once.
    assign mem_addr  = (r_state == ACCESS) ? r_addr : '0;
    assign mem_wdata = ((r_state == ACCESS) && r_we) ? r_wdata : '0;
    assign mem_w_en  = (r_state == ACCESS) && r_we && w_zero;
    assign if_ack    = (r_state == RESP) && (r_grant == GNT_FETCH);
    assign d_ack     = (r_state == RESP) && (r_grant == GNT_DATA);
    assign busy      = (r_state != IDLE);
    assign if_instr  = r_if_instr;
    assign d_rdata   = r_d_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_master.sv
// ============================================================================
// Module      : tb_mem_access_master
// Description : Directed self-checking bench for mem_access_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_master;

    logic clk;
    logic rst;
    logic tb_init;

    // WAIT_CYCLES = 0 instance
    logic       if_req0, if_ack0, d_req0, d_we0, d_ack0, mem_w_en0, busy0;
    logic [3:0] if_addr0, d_addr0;
    logic [7:0] if_instr0, d_wdata0, d_rdata0, mem_wdata0, mem_rdata0;
    logic [4:0] mem_addr0;
    logic [7:0] mem0 [32];

    // WAIT_CYCLES = 2 instance
    logic       if_req2, if_ack2, d_req2, d_we2, d_ack2, mem_w_en2, busy2;
    logic [3:0] if_addr2, d_addr2;
    logic [7:0] if_instr2, d_wdata2, d_rdata2, mem_wdata2, mem_rdata2;
    logic [4:0] mem_addr2;
    logic [7:0] mem2 [32];

    int n_checks;
    int n_errors;

    mem_access_master #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req0), .if_addr(if_addr0), .if_ack(if_ack0), .if_instr(if_instr0),
        .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
        .d_ack(d_ack0), .d_rdata(d_rdata0),
        .mem_w_en(mem_w_en0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0), .busy(busy0)
    );

    mem_access_master #(.WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst),
        .if_req(if_req2), .if_addr(if_addr2), .if_ack(if_ack2), .if_instr(if_instr2),
        .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
        .d_ack(d_ack2), .d_rdata(d_rdata2),
        .mem_w_en(mem_w_en2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .busy(busy2)
    );

    assign mem_rdata0 = mem0[mem_addr0];
    assign mem_rdata2 = mem2[mem_addr2];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 32; i++) begin
                mem0[i] <= 8'h00;
                mem2[i] <= 8'h00;
            end
            mem0[1]  <= 8'h11;
            mem0[3]  <= 8'hA5;
            mem0[16] <= 8'h22;
            mem0[21] <= 8'h55;
        end else begin
            if (mem_w_en0) mem0[mem_addr0] <= mem_wdata0;
            if (mem_w_en2) mem2[mem_addr2] <= mem_wdata2;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All outputs of the WAIT=0 instance packed for one-shot zero checks.
    function automatic logic [31:0] outs0();
        return {if_ack0, d_ack0, mem_w_en0, busy0, mem_addr0, if_instr0, d_rdata0, 1'b0} |
               {24'd0, mem_wdata0};
    endfunction

    logic [2:0] tie_exp [9];
    logic [2:0] w2_exp  [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        tb_init = 1'b1;
        {if_req0, d_req0, d_we0, if_req2, d_req2, d_we2} = '0;
        {if_addr0, d_addr0, if_addr2, d_addr2} = '0;
        {d_wdata0, d_wdata2} = '0;
        step();
        step();
        tb_init = 1'b0;
        check("reset_outputs", outs0(), 32'd0);
        check("reset_busy2", {31'd0, busy2}, 32'd0);
        rst = 1'b0;
        step();

        // Fetch, WAIT=0
        if_req0 = 1'b1; if_addr0 = 4'd3;
        step();
        check("fetch_addr", {27'd0, mem_addr0}, 32'd3);
        check("fetch_busy_ack", {30'd0, busy0, if_ack0}, 32'b10);
        step();
        check("fetch_ack", {31'd0, if_ack0}, 32'd1);
        check("fetch_instr", {24'd0, if_instr0}, 32'hA5);
        if_req0 = 1'b0;
        step();
        check("fetch_idle", {29'd0, busy0, if_ack0, d_ack0}, 32'd0);

        // Store then load
        d_req0 = 1'b1; d_we0 = 1'b1; d_addr0 = 4'd2; d_wdata0 = 8'h3C;
        step();
        check("store_wen", {31'd0, mem_w_en0}, 32'd1);
        check("store_addr", {27'd0, mem_addr0}, 32'd18);
        check("store_wdata", {24'd0, mem_wdata0}, 32'h3C);
        step();
        check("store_ack_noen", {30'd0, d_ack0, mem_w_en0}, 32'b10);
        check("store_rdata_kept", {24'd0, d_rdata0}, 32'd0);
        check("store_mem", {24'd0, mem0[18]}, 32'h3C);
        d_req0 = 1'b0; d_we0 = 1'b0;
        step();
        d_req0 = 1'b1;
        step();
        check("load_addr_noen", {26'd0, mem_w_en0, mem_addr0}, 32'd18);
        step();
        check("load_ack", {31'd0, d_ack0}, 32'd1);
        check("load_rdata", {24'd0, d_rdata0}, 32'h3C);
        d_req0 = 1'b0;
        step();

        // Tie after reset: {busy, if_ack, d_ack} per cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        tie_exp = '{3'b100, 3'b110, 3'b000, 3'b100, 3'b101, 3'b000, 3'b100, 3'b110, 3'b000};
        if_req0 = 1'b1; if_addr0 = 4'd1;
        d_req0 = 1'b1; d_we0 = 1'b0; d_addr0 = 4'd0;
        for (int c = 0; c < 9; c++) begin
            step();
            check($sformatf("tie_cycle%0d", c), {29'd0, busy0, if_ack0, d_ack0}, {29'd0, tie_exp[c]});
            if (c == 7) begin
                if_req0 = 1'b0;
                d_req0  = 1'b0;
            end
        end
        check("tie_instr", {24'd0, if_instr0}, 32'h11);
        check("tie_rdata", {24'd0, d_rdata0}, 32'h22);

        // Reset during ACCESS of a store
        d_req0 = 1'b1; d_we0 = 1'b1; d_addr0 = 4'd5; d_wdata0 = 8'hEE;
        step();
        check("rst_pre_wen", {31'd0, mem_w_en0}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_outputs", outs0(), 32'd0);
        d_req0 = 1'b0; d_we0 = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("rst_noack%0d", c), {30'd0, d_ack0, busy0}, 32'd0);
        end
        check("rst_mem_kept", {24'd0, mem0[21]}, 32'h55);

        // Request dropped after one IDLE cycle
        d_req0 = 1'b1; d_we0 = 1'b0; d_addr0 = 4'd0;
        step();
        d_req0 = 1'b0;
        check("drop_busy", {31'd0, busy0}, 32'd1);
        step();
        check("drop_ack", {31'd0, d_ack0}, 32'd1);
        check("drop_rdata", {24'd0, d_rdata0}, 32'h22);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("drop_idle%0d", c), {30'd0, busy0, d_ack0}, 32'd0);
        end

        // WAIT_CYCLES=2 store: {busy, mem_w_en, d_ack} per cycle
        w2_exp = '{3'b100, 3'b100, 3'b110, 3'b101, 3'b000};
        d_req2 = 1'b1; d_we2 = 1'b1; d_addr2 = 4'd4; d_wdata2 = 8'h77;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 0) check("w2_addr", {27'd0, mem_addr2}, 32'd20);
            check($sformatf("w2_cycle%0d", c), {29'd0, busy2, mem_w_en2, d_ack2}, {29'd0, w2_exp[c]});
            if (c == 3) begin
                d_req2 = 1'b0;
                d_we2  = 1'b0;
            end
        end
        check("w2_mem", {24'd0, mem2[20]}, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Requester-side controller for the shared 32x8 instruction/data memory.
- Accepts instruction-fetch requests and data load/store requests, and arbitrates between them round-robin.
- Maps each request into the unified address space: instructions at 0..15, data at 16..31.
- Sequences each access through a small FSM with optional wait states, captures read data into registers, and returns a one-cycle ack to the requester.
- Sits between the multicycle datapath (PC/IR side and load/store side) and the memory.

Parameters:
- ADDR_W, 5, memory address width.
- DATA_W, 8, memory data width.
- OFF_W, 4, region offset width; each region holds 16 words.
- INST_BASE, 0, base address of the instruction region.
- DATA_BASE, 16, base address of the data region.
- WAIT_CYCLES, 0, extra ACCESS cycles per transaction (0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  OFF_W  instruction word offset.
- if_ack  out  1  one-cycle pulse; if_instr is valid in this cycle.
- if_instr  out  DATA_W  registered fetched instruction.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  OFF_W  data word offset.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_W  registered load data.
- mem_w_en  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data (combinational from mem_addr).
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (asynchronous, immediate):
  - State goes to IDLE; the wait counter clears.
  - All outputs go to 0: if_ack, d_ack, if_instr, d_rdata, mem_w_en, mem_addr, mem_wdata, busy.
  - last_grant resets to DATA, so the first tie goes to fetch.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one is high, grant it. If both are high, grant the port that is not last_grant.
  - On grant, latch the port, the mapped address (INST_BASE+if_addr or DATA_BASE+d_addr), the we bit (forced to 0 for fetch) and d_wdata. Update last_grant, load the counter with WAIT_CYCLES, and move to ACCESS.
- ACCESS:
  - mem_addr is driven from the latched address; mem_wdata is the latched data for stores and 0 otherwise.
  - While the counter is nonzero, decrement it and stay in ACCESS.
  - When the counter is 0:
    - Store: mem_w_en = 1 for this cycle only.
    - Load or fetch: sample mem_rdata into d_rdata or if_instr at the clock edge.
    - Move to RESP.
- RESP:
  - Assert the granted port's ack for exactly one cycle, then return to IDLE.
  - mem_addr returns to 0 and mem_w_en stays 0.
- Latency: ack is asserted WAIT_CYCLES+2 cycles after the sampling edge in IDLE. Minimum transaction length is 3 cycles including IDLE.
- Requester rules:
  - The requester drops req in the cycle after ack; the IDLE cycle that follows RESP prevents double service.
  - Changes to req, address or data after the grant are ignored until the next IDLE.
- mem_w_en is never high outside the final ACCESS cycle; it is never high in IDLE or RESP.
- A store does not modify d_rdata. if_instr and d_rdata hold their value until the next read on the same port.
- If rst is asserted during ACCESS, mem_w_en drops immediately, the write is not committed, and no ack is issued.
- If rst is asserted during RESP, the ack is cut short and the captured data clears to 0.
- Address arithmetic is a zero-extended add with no carry out of ADDR_W. Offsets cannot leave their region.

Decomposition:
- Package mem_map_pkg holds:
  - ADDR_W, DATA_W, OFF_W, INST_BASE, DATA_BASE;
  - the state enum {IDLE, ACCESS, RESP};
  - the grant enum {GNT_FETCH, GNT_DATA}.
- One natural sub-module: access_timer, a 4-bit loadable down-counter with a zero flag.

Test Plan:
- Fetch, WAIT=0: mem[3]=8'hA5, if_addr=3 -> mem_addr=5'd3 in cycle 1, if_ack in cycle 2, if_instr=8'hA5.
- Store then load: d_addr=2, d_wdata=8'h3C, d_we=1 -> exactly one mem_w_en cycle with mem_addr=5'd18, and d_rdata unchanged. Then load d_addr=2 -> d_ack with d_rdata=8'h3C.
- Tie after reset, with both requests held: if_req, if_addr=1 and d_req load d_addr=0 (mem[1]=8'h11, mem[16]=8'h22) -> grants in order FETCH, DATA, FETCH. Outputs if_instr=8'h11 and d_rdata=8'h22. busy stays high except during the IDLE cycles.
- WAIT_CYCLES=2, store -> ACCESS lasts 3 cycles, mem_w_en only in the 3rd, d_ack 4 cycles after the sampling edge.
- rst pulsed in the first ACCESS cycle of a store to d_addr=5 -> mem_w_en=0 immediately, no d_ack, mem[21] unchanged, all outputs 0.
- Request dropped early: d_req pulsed for one cycle in IDLE -> transaction still completes with d_ack. No second transaction starts while req is low.
